// File: rtl/ex_alu_md_pkg.sv
// Shared encodings for the execute stage: result-class selects, ALU op codes
// (base + M extension) and the multiply/divide FSM state type.
package ex_alu_md_pkg;

  localparam int unsigned AluOpW   = 8;
  localparam int unsigned AluSelW  = 3;
  localparam int unsigned RegAddrW = 5;

  localparam logic [AluSelW-1:0] EXE_RES_NOP    = 3'd0;
  localparam logic [AluSelW-1:0] EXE_RES_LOGIC  = 3'd1;
  localparam logic [AluSelW-1:0] EXE_RES_SHIFT  = 3'd2;
  localparam logic [AluSelW-1:0] EXE_RES_ARITH  = 3'd3;
  localparam logic [AluSelW-1:0] EXE_RES_MULDIV = 3'd4;

  localparam logic [AluOpW-1:0] EXE_XOR_OP  = 8'h01;
  localparam logic [AluOpW-1:0] EXE_OR_OP   = 8'h02;
  localparam logic [AluOpW-1:0] EXE_AND_OP  = 8'h03;
  localparam logic [AluOpW-1:0] EXE_SLL_OP  = 8'h04;
  localparam logic [AluOpW-1:0] EXE_SRL_OP  = 8'h05;
  localparam logic [AluOpW-1:0] EXE_SRA_OP  = 8'h06;
  localparam logic [AluOpW-1:0] EXE_ADD_OP  = 8'h07;
  localparam logic [AluOpW-1:0] EXE_SUB_OP  = 8'h08;
  localparam logic [AluOpW-1:0] EXE_SLT_OP  = 8'h09;
  localparam logic [AluOpW-1:0] EXE_SLTU_OP = 8'h0A;

  // M extension: bit 2 selects divide, bits [1:0] select the variant.
  localparam logic [AluOpW-1:0] EXE_MUL_OP    = 8'h10;
  localparam logic [AluOpW-1:0] EXE_MULH_OP   = 8'h11;
  localparam logic [AluOpW-1:0] EXE_MULHSU_OP = 8'h12;
  localparam logic [AluOpW-1:0] EXE_MULHU_OP  = 8'h13;
  localparam logic [AluOpW-1:0] EXE_DIV_OP    = 8'h14;
  localparam logic [AluOpW-1:0] EXE_DIVU_OP   = 8'h15;
  localparam logic [AluOpW-1:0] EXE_REM_OP    = 8'h16;
  localparam logic [AluOpW-1:0] EXE_REMU_OP   = 8'h17;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

  function automatic logic is_md_op(logic [AluOpW-1:0] op);
    return (op >= EXE_MUL_OP) && (op <= EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// done_o marks the cycle whose result_o must be captured by the caller.
module ex_muldiv_iter
  import ex_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [1:0]      sel_q;
  logic            neg_q, neg_rem_q;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, sp_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_n, lo_n, quo, rem, iter_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic            last_iter;

  // Start-time decode: operand signs, magnitudes and the RISC-V divide corner cases.
  always_comb begin
    is_div   = op_i[2];
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_i[0] : ~op_i[1];
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_abs    = a_neg ? -a_i : a_i;
    b_abs    = b_neg ? -b_i : b_i;
    div_zero = (b_i == '0);
    div_ovf  = ~op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
    special  = is_div & (div_zero | div_ovf);
    if (div_zero) sp_res = op_i[1] ? a_i : '1;
    else          sp_res = op_i[1] ? '0 : a_i;
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (state_q == StMul) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_n = div_diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_n = div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_n : lo_n;
    rem    = neg_rem_q ? -hi_n : hi_n;
    if (state_q == StMul) iter_res = (sel_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else                  iter_res = sel_q[1] ? rem : quo;
  end

  assign idle_o    = (state_q == StIdle);
  assign busy_o    = (state_q == StMul) || (state_q == StDiv);
  assign last_iter = busy_o && (cnt_q == CntW'(XLEN - 1));
  assign done_o    = ~flush_i & ((idle_o & start_i & special) | last_iter);
  assign result_o  = idle_o ? sp_res : iter_res;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      sel_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (special) begin
              state_q <= StDone;
            end else begin
              state_q   <= is_div ? StDiv : StMul;
              cnt_q     <= '0;
              hi_q      <= '0;
              lo_q      <= is_div ? a_abs : b_abs;
              opnd_q    <= is_div ? b_abs : a_abs;
              sel_q     <= op_i[1:0];
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        StMul, StDiv: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/ex_alu_md.sv
// Execute stage: single-cycle logic/shift/arith ALU plus the iterative mul/div unit,
// with registered result and a stall request while a multi-cycle op is running.
module ex_alu_md
  import ex_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [AluOpW-1:0]   aluop,
  input  logic [AluSelW-1:0]  alusel,
  input  logic [XLEN-1:0]     opv1,
  input  logic [XLEN-1:0]     opv2,
  input  logic [RegAddrW-1:0] reg_waddr_i,
  input  logic                we_i,
  output logic                out_valid,
  output logic [RegAddrW-1:0] reg_waddr_o,
  output logic                we_o,
  output logic [XLEN-1:0]     reg_wdata,
  output logic                stallreq
);

  logic                md_idle, md_busy, md_done;
  logic [XLEN-1:0]     md_result;
  logic                accept, is_md, md_start, single_vld;
  logic [XLEN-1:0]     alu_res;
  logic [SHW-1:0]      shamt;

  logic                out_valid_d, out_valid_q;
  logic [XLEN-1:0]     wdata_d, wdata_q;
  logic [RegAddrW-1:0] waddr_d, waddr_q;
  logic                we_d, we_q;

  assign accept   = in_valid & md_idle & ~flush;
  assign is_md    = (alusel == EXE_RES_MULDIV) && is_md_op(aluop);
  assign md_start = accept & is_md;
  assign stallreq = ~flush & (md_busy | md_start);
  assign shamt    = opv2[SHW-1:0];

  always_comb begin
    alu_res    = '0;
    single_vld = 1'b0;
    case (alusel)
      EXE_RES_LOGIC: begin
        single_vld = 1'b1;
        case (aluop)
          EXE_XOR_OP: alu_res = opv1 ^ opv2;
          EXE_OR_OP:  alu_res = opv1 | opv2;
          EXE_AND_OP: alu_res = opv1 & opv2;
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        single_vld = 1'b1;
        case (aluop)
          EXE_SLL_OP: alu_res = opv1 << shamt;
          EXE_SRL_OP: alu_res = opv1 >> shamt;
          EXE_SRA_OP: alu_res = $signed(opv1) >>> shamt;
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        single_vld = 1'b1;
        case (aluop)
          EXE_ADD_OP:  alu_res = opv1 + opv2;
          EXE_SUB_OP:  alu_res = opv1 - opv2;
          EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opv1) < $signed(opv2))};
          EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, (opv1 < opv2)};
          default:     alu_res = '0;
        endcase
      end
      // Unknown M-class codes complete in one cycle with a zero result.
      EXE_RES_MULDIV: single_vld = ~is_md_op(aluop);
      default:        single_vld = 1'b0;
    endcase
  end

  ex_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .start_i  (md_start),
    .op_i     (aluop[2:0]),
    .a_i      (opv1),
    .b_i      (opv2),
    .idle_o   (md_idle),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Destination is latched at accept so it survives the multi-cycle window.
  always_comb begin
    out_valid_d = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    if (accept) begin
      waddr_d = reg_waddr_i;
      we_d    = we_i;
    end
    if (accept && single_vld) begin
      out_valid_d = 1'b1;
      wdata_d     = alu_res;
    end else if (md_done) begin
      out_valid_d = 1'b1;
      wdata_d     = md_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign reg_wdata   = wdata_q;
  assign reg_waddr_o = waddr_q;
  assign we_o        = we_q & out_valid_q;

endmodule

// File: tb/tb_ex_alu_md.sv
// Scoreboard bench for ex_alu_md: directed ops push expected results with their
// expected cycle; monitors pop and compare whenever out_valid is seen.
module tb_ex_alu_md;
  import ex_alu_md_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, flush, in_valid, we_i;
  logic [AluOpW-1:0]   aluop;
  logic [AluSelW-1:0]  alusel;
  logic [31:0]         opv1, opv2, wdata;
  logic [RegAddrW-1:0] waddr_i, waddr_o;
  logic                out_valid, we_o, stallreq;

  logic                flush64, in_valid64, we_i64;
  logic [AluOpW-1:0]   aluop64;
  logic [AluSelW-1:0]  alusel64;
  logic [63:0]         a64, b64, wdata64;
  logic [RegAddrW-1:0] waddr_i64, waddr_o64;
  logic                out_valid64, we_o64, stallreq64;

  ex_alu_md u_dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .aluop       (aluop),
    .alusel      (alusel),
    .opv1        (opv1),
    .opv2        (opv2),
    .reg_waddr_i (waddr_i),
    .we_i        (we_i),
    .out_valid   (out_valid),
    .reg_waddr_o (waddr_o),
    .we_o        (we_o),
    .reg_wdata   (wdata),
    .stallreq    (stallreq)
  );

  ex_alu_md #(
    .XLEN (64)
  ) u_dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush64),
    .in_valid    (in_valid64),
    .aluop       (aluop64),
    .alusel      (alusel64),
    .opv1        (a64),
    .opv2        (b64),
    .reg_waddr_i (waddr_i64),
    .we_i        (we_i64),
    .out_valid   (out_valid64),
    .reg_waddr_o (waddr_o64),
    .we_o        (we_o64),
    .reg_wdata   (wdata64),
    .stallreq    (stallreq64)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  wa;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb64[$];
  exp_t e, e64;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (we_o) chk("we_o_gated", 64'(out_valid), 64'd1);
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got wdata 0x%0h at cycle %0d, want none", wdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("wdata", 64'(wdata), e.data);
        chk("waddr", 64'(waddr_o), 64'(e.wa));
        chk("we_o", 64'(we_o), 64'(e.we));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid64) begin
      if (sb64.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid64: got wdata 0x%0h at cycle %0d, want none",
                 wdata64, cyc);
      end else begin
        e64 = sb64.pop_front();
        chk("wdata64", wdata64, e64.data);
        chk("latency64", 64'(cyc), 64'(e64.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one op for one cycle; lat==0 means no result is expected.
  task automatic issue(input logic [AluSelW-1:0] sel, input logic [AluOpW-1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                       input logic exp_stall, input int lat, input logic [31:0] exp);
    exp_t x;
    in_valid = 1'b1;
    alusel   = sel;
    aluop    = op;
    opv1     = a;
    opv2     = b;
    waddr_i  = wa;
    we_i     = wa[0];
    if (lat > 0) begin
      x.data = 64'(exp);
      x.wa   = wa;
      x.we   = wa[0];
      x.cyc  = cyc + lat;
      sb.push_back(x);
    end
    @(negedge clk);
    chk($sformatf("stall_T_op%02h", op), 64'(stallreq), 64'(exp_stall));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Covers T+1..T+n with stallreq high (optionally poking new ops), then T+n+1 low.
  task automatic busy(input int n, input logic poke);
    for (int i = 1; i <= n; i++) begin
      in_valid = poke & i[0];
      alusel   = (i % 4 == 3) ? EXE_RES_MULDIV : EXE_RES_ARITH;
      aluop    = (i % 4 == 3) ? EXE_DIVU_OP : EXE_ADD_OP;
      opv1     = 32'(i);
      opv2     = 32'd1;
      waddr_i  = 5'd31;
      we_i     = 1'b1;
      @(negedge clk);
      chk("stall_busy", 64'(stallreq), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_done", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t x;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; we_i = 1'b0;
    aluop = '0; alusel = '0; opv1 = '0; opv2 = '0; waddr_i = '0;
    flush64 = 1'b0; in_valid64 = 1'b0; we_i64 = 1'b0; aluop64 = '0;
    alusel64 = EXE_RES_MULDIV; a64 = '0; b64 = '0; waddr_i64 = '0;
    step(3);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_we_o", 64'(we_o), 64'd0);
    chk("rst_waddr", 64'(waddr_o), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);

    // Single-cycle ops, back to back.
    issue(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b0, 1, 32'h8000_0000);
    issue(EXE_RES_SHIFT, EXE_SRA_OP, 32'h8000_0000, 32'd4, 5'd2, 1'b0, 1, 32'hF800_0000);
    issue(EXE_RES_SHIFT, EXE_SRL_OP, 32'h8000_0000, 32'd4, 5'd3, 1'b0, 1, 32'h0800_0000);
    issue(EXE_RES_SHIFT, EXE_SLL_OP, 32'h1, 32'h3F, 5'd4, 1'b0, 1, 32'h8000_0000);
    issue(EXE_RES_LOGIC, EXE_XOR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 1'b0, 1, 32'h0FF0_0FF0);
    issue(EXE_RES_LOGIC, EXE_OR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b0, 1, 32'hFFF0_FFF0);
    issue(EXE_RES_LOGIC, EXE_AND_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 1'b0, 1, 32'hF000_F000);
    issue(EXE_RES_LOGIC, 8'h7F, 32'hFFFF_FFFF, 32'h1, 5'd8, 1'b0, 1, 32'h0);
    issue(EXE_RES_ARITH, EXE_SUB_OP, 32'h0, 32'h1, 5'd9, 1'b0, 1, 32'hFFFF_FFFF);
    issue(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFF_FFFF, 32'h1, 5'd10, 1'b0, 1, 32'h1);
    issue(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'h1, 5'd11, 1'b0, 1, 32'h0);
    issue(EXE_RES_ARITH, EXE_SLTU_OP, 32'h1, 32'hFFFF_FFFF, 5'd12, 1'b0, 1, 32'h1);
    issue(EXE_RES_MULDIV, 8'h1F, 32'h5, 32'h3, 5'd13, 1'b0, 1, 32'h0);
    issue(3'd7, EXE_ADD_OP, 32'h1, 32'h1, 5'd14, 1'b0, 0, 32'h0);
    step(1);

    // Multi-cycle multiply, stall window T..T+32, result at T+33.
    issue(EXE_RES_MULDIV, EXE_MULH_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b1, 33, 32'h0);
    busy(32, 1'b1);
    issue(EXE_RES_MULDIV, EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1, 33,
          32'hFFFF_FFFE);
    busy(32, 1'b0);
    issue(EXE_RES_MULDIV, EXE_MUL_OP, 32'hFFFF_FFFD, 32'd7, 5'd17, 1'b1, 33, 32'hFFFF_FFEB);
    busy(32, 1'b1);
    issue(EXE_RES_MULDIV, EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b1, 33,
          32'hFFFF_FFFF);
    busy(32, 1'b0);

    // Divide corner cases: one cycle, stall in T only, next op after DONE.
    issue(EXE_RES_MULDIV, EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1'b1, 1, 32'h8000_0000);
    step(1);
    issue(EXE_RES_MULDIV, EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b1, 1, 32'h0);
    step(1);
    issue(EXE_RES_MULDIV, EXE_DIVU_OP, 32'd7, 32'd0, 5'd21, 1'b1, 1, 32'hFFFF_FFFF);
    step(1);
    issue(EXE_RES_MULDIV, EXE_REMU_OP, 32'd7, 32'd0, 5'd22, 1'b1, 1, 32'd7);
    step(1);
    issue(EXE_RES_MULDIV, EXE_DIV_OP, 32'd5, 32'd0, 5'd23, 1'b1, 1, 32'hFFFF_FFFF);
    step(1);

    // Iterative divides with the ignored-op pokes in the busy window.
    issue(EXE_RES_MULDIV, EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 5'd24, 1'b1, 33, 32'hFFFF_FFFD);
    busy(32, 1'b1);
    issue(EXE_RES_MULDIV, EXE_REM_OP, 32'hFFFF_FFF9, 32'd2, 5'd25, 1'b1, 33, 32'hFFFF_FFFF);
    busy(32, 1'b1);
    issue(EXE_RES_MULDIV, EXE_DIVU_OP, 32'd100, 32'd7, 5'd26, 1'b1, 33, 32'd14);
    busy(32, 1'b0);
    issue(EXE_RES_MULDIV, EXE_REMU_OP, 32'd100, 32'd7, 5'd27, 1'b1, 33, 32'd2);
    busy(32, 1'b0);

    // Flush at T+10 of a DIVU; ADD at T+11 gives its result at T+12.
    issue(EXE_RES_MULDIV, EXE_DIVU_OP, 32'd100, 32'd7, 5'd28, 1'b1, 0, 32'h0);
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    issue(EXE_RES_ARITH, EXE_ADD_OP, 32'd3, 32'd4, 5'd29, 1'b0, 1, 32'd7);
    // Flush beats in_valid in the same cycle.
    flush    = 1'b1;
    in_valid = 1'b1;
    alusel   = EXE_RES_ARITH;
    aluop    = EXE_ADD_OP;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_prio_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a MUL clears every output.
    issue(EXE_RES_MULDIV, EXE_MUL_OP, 32'd3, 32'd5, 5'd22, 1'b1, 0, 32'h0);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_we_o", 64'(we_o), 64'd0);
    chk("midrst_waddr", 64'(waddr_o), 64'd0);
    chk("midrst_wdata", 64'(wdata), 64'd0);
    chk("midrst_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    issue(EXE_RES_ARITH, EXE_ADD_OP, 32'd2, 32'd2, 5'd3, 1'b0, 1, 32'd4);
    step(3);

    // 64-bit instance: 65-cycle latency.
    in_valid64 = 1'b1;
    aluop64    = EXE_MULHU_OP;
    a64        = '1;
    b64        = '1;
    waddr_i64  = 5'd9;
    we_i64     = 1'b1;
    x.data = 64'hFFFF_FFFF_FFFF_FFFE; x.wa = 5'd9; x.we = 1'b1; x.cyc = cyc + 65;
    sb64.push_back(x);
    @(negedge clk);
    chk("stall64_T", 64'(stallreq64), 64'd1);
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    step(70);
    in_valid64 = 1'b1;
    aluop64    = EXE_MUL_OP;
    x.data = 64'h1; x.cyc = cyc + 65;
    sb64.push_back(x);
    step(1);
    in_valid64 = 1'b0;
    step(70);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("sb64_drained", 64'(sb64.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
